risc_ctrl_param: RTL

Parametrised multicycle control unit for the RISC datapath. It decodes `{opcode, src, dest}` instructions into register-load, bus-select, PC and memory strobes for a register file of `NREG` entries. It adds the following behaviour to the base controller:
- memory wait-state handshake,
- stall timeout,
- explicit HALT opcode with resume,
- sticky error reporting.

It sits between the instruction register and the datapath/memory mux controls.

---
 rtl/risc_ctrl_param.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/risc_ctrl_param.sv
// Multicycle control unit for the RISC datapath.
// Adds memory wait states, stall timeout, HALT/resume and a sticky error flag.
module risc_ctrl_param #(
    parameter int NREG     = 4,
    parameter int WAIT_MAX = 15,
    localparam int RW      = $clog2(NREG)
) (
    input  logic              nclk,
    input  logic              rst,
    input  logic [4+2*RW-1:0] instruction,
    input  logic              zero,
    input  logic              mem_ready,
    input  logic              resume,
    output logic [NREG-1:0]   L_R,
    output logic              L_PC,
    output logic              Inc_PC,
    output logic              L_IR,
    output logic              L_ADD_R,
    output logic              L_R_Y,
    output logic              L_R_Z,
    output logic              write,
    output logic [RW:0]       Sel_Bus1,
    output logic [1:0]        Sel_Bus2,
    output logic              halted,
    output logic              err,
    output logic [3:0]        state
);

    localparam int CW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_FET1 = 4'd1,
        S_FET2 = 4'd2,
        S_DEC  = 4'd3,
        S_EX1  = 4'd4,
        S_RD1  = 4'd5,
        S_RD2  = 4'd6,
        S_WR1  = 4'd7,
        S_WR2  = 4'd8,
        S_BR1  = 4'd9,
        S_BR2  = 4'd10,
        S_HALT = 4'd11
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_NOT  = 4'd4;
    localparam logic [3:0] OP_RD   = 4'd5;
    localparam logic [3:0] OP_WR   = 4'd6;
    localparam logic [3:0] OP_BR   = 4'd7;
    localparam logic [3:0] OP_BRZ  = 4'd8;
    localparam logic [3:0] OP_HALT = 4'd15;

    localparam logic [RW:0] SEL_PC = (RW+1)'(NREG);

    state_t          cur;
    state_t          nxt;
    logic [CW-1:0]   wcnt;
    logic [CW-1:0]   wcnt_nxt;
    logic            err_q;
    logic            err_nxt;
    logic [3:0]      opcode;
    logic [RW-1:0]   src;
    logic [RW-1:0]   dest;
    logic [NREG-1:0] dest_oh;
    logic            mem_st;
    logic            stall;
    logic            tmo;

    assign opcode  = instruction[4+2*RW-1:2*RW];
    assign src     = instruction[2*RW-1:RW];
    assign dest    = instruction[RW-1:0];
    assign dest_oh = NREG'(1) << dest;

    assign mem_st = (cur == S_FET2) || (cur == S_RD1) || (cur == S_RD2) ||
                    (cur == S_WR1)  || (cur == S_WR2) || (cur == S_BR1) ||
                    (cur == S_BR2);
    assign stall  = mem_st && !mem_ready;
    assign tmo    = stall && (wcnt == CW'(WAIT_MAX));

    assign state  = cur;
    assign err    = err_q;

    always_ff @(posedge nclk) begin
        if (rst) begin
            cur   <= S_IDLE;
            err_q <= 1'b0;
            wcnt  <= '0;
        end else begin
            cur   <= nxt;
            err_q <= err_nxt;
            wcnt  <= wcnt_nxt;
        end
    end

    always_comb begin
        nxt     = cur;
        err_nxt = err_q;
        if (tmo) begin
            nxt     = S_HALT;
            err_nxt = 1'b1;
        end else if (!stall) begin
            case (cur)
                S_IDLE: nxt = S_FET1;
                S_FET1: nxt = S_FET2;
                S_FET2: nxt = S_DEC;
                S_DEC: begin
                    case (opcode)
                        OP_NOP:                 nxt = S_FET1;
                        OP_ADD, OP_SUB, OP_AND: nxt = S_EX1;
                        OP_NOT:                 nxt = S_FET1;
                        OP_RD:                  nxt = S_RD1;
                        OP_WR:                  nxt = S_WR1;
                        OP_BR:                  nxt = S_BR1;
                        OP_BRZ:                 nxt = zero ? S_BR1 : S_FET1;
                        OP_HALT:                nxt = S_HALT;
                        default: begin
                            nxt     = S_HALT;
                            err_nxt = 1'b1;
                        end
                    endcase
                end
                S_EX1: nxt = S_FET1;
                S_RD1: nxt = S_RD2;
                S_RD2: nxt = S_FET1;
                S_WR1: nxt = S_WR2;
                S_WR2: nxt = S_FET1;
                S_BR1: nxt = S_BR2;
                S_BR2: nxt = S_FET1;
                S_HALT: begin
                    if (resume) begin
                        nxt     = S_FET1;
                        err_nxt = 1'b0;
                    end
                end
                default: nxt = S_IDLE;
            endcase
        end
        // the counter only measures the current stay in one state
        if (nxt != cur)
            wcnt_nxt = '0;
        else if (stall)
            wcnt_nxt = wcnt + 1'b1;
        else
            wcnt_nxt = wcnt;
    end

    always_comb begin
        L_R      = '0;
        L_PC     = 1'b0;
        Inc_PC   = 1'b0;
        L_IR     = 1'b0;
        L_ADD_R  = 1'b0;
        L_R_Y    = 1'b0;
        L_R_Z    = 1'b0;
        write    = 1'b0;
        Sel_Bus1 = '0;
        Sel_Bus2 = 2'd0;
        halted   = 1'b0;
        case (cur)
            S_FET1: begin
                Sel_Bus1 = SEL_PC;
                Sel_Bus2 = 2'd1;
                L_ADD_R  = 1'b1;
            end
            S_FET2: begin
                Sel_Bus2 = 2'd2;
                L_IR     = mem_ready;
                Inc_PC   = mem_ready;
            end
            S_DEC: begin
                case (opcode)
                    OP_ADD, OP_SUB, OP_AND: begin
                        Sel_Bus1 = {1'b0, src};
                        Sel_Bus2 = 2'd1;
                        L_R_Y    = 1'b1;
                    end
                    OP_NOT: begin
                        Sel_Bus1 = {1'b0, src};
                        L_R_Z    = 1'b1;
                        L_R      = dest_oh;
                    end
                    OP_RD, OP_WR, OP_BR: begin
                        Sel_Bus1 = SEL_PC;
                        Sel_Bus2 = 2'd1;
                        L_ADD_R  = 1'b1;
                    end
                    OP_BRZ: begin
                        if (zero) begin
                            Sel_Bus1 = SEL_PC;
                            Sel_Bus2 = 2'd1;
                            L_ADD_R  = 1'b1;
                        end else begin
                            Inc_PC = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            S_EX1: begin
                Sel_Bus1 = {1'b0, dest};
                L_R_Z    = 1'b1;
                L_R      = dest_oh;
            end
            S_RD1, S_WR1: begin
                Sel_Bus2 = 2'd2;
                Inc_PC   = mem_ready;
                L_ADD_R  = mem_ready;
            end
            S_RD2: begin
                Sel_Bus2 = 2'd2;
                L_R      = mem_ready ? dest_oh : '0;
            end
            S_WR2: begin
                Sel_Bus1 = {1'b0, src};
                write    = !tmo;
            end
            S_BR1: begin
                Sel_Bus2 = 2'd2;
                L_ADD_R  = mem_ready;
            end
            S_BR2: begin
                Sel_Bus2 = 2'd2;
                L_PC     = mem_ready;
            end
            S_HALT: halted = 1'b1;
            default: ;
        endcase
    end

endmodule
